// File: rtl/div_iter_ctrl.sv
// div_iter_ctrl: multi-cycle signed/unsigned integer divider sequencer.
// A non-restoring division produces one quotient bit per cycle. A single
// fixup cycle then restores a negative partial remainder and applies the
// result signs. Results are handed to the consumer with a valid/ack
// handshake. busy_o stalls EX while an operation is in flight.
module div_iter_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  result_valid_o,
    input  logic                  result_ack_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE_W    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] MIN_INT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_INIT = CNT_WIDTH'(DATA_WIDTH);

    // Two's complement negation with DATA_WIDTH-bit wrap.
    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] val);
        return ~val + ONE_W;
    endfunction

    // Magnitude of an operand; MIN_INT stays MIN_INT, read as unsigned.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] val,
                                                        input logic is_signed);
        logic [DATA_WIDTH-1:0] res;
        if (is_signed && val[DATA_WIDTH-1]) begin
            res = negate(val);
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH:0]   prem_q, prem_d;     // signed partial remainder
    logic [DATA_WIDTH-1:0] quo_q, quo_d;       // dividend shifting out, quotient shifting in
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
    logic                  q_neg_q, q_neg_d;
    logic                  r_neg_q, r_neg_d;
    logic [DATA_WIDTH-1:0] quot_res_q, quot_res_d;
    logic [DATA_WIDTH-1:0] rem_res_q, rem_res_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH:0]   shifted_s;
    logic [DATA_WIDTH:0]   step_s;
    logic [DATA_WIDTH:0]   dvsr_ext_s;
    logic [DATA_WIDTH-1:0] rem_fix_s;
    logic                  a_neg_s;
    logic                  b_neg_s;

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            prem_q     <= {(DATA_WIDTH+1){1'b0}};
            quo_q      <= ZERO_W;
            dvsr_q     <= ZERO_W;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            quot_res_q <= ZERO_W;
            rem_res_q  <= ZERO_W;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prem_q     <= prem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            quot_res_q <= quot_res_d;
            rem_res_q  <= rem_res_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state, one non-restoring step, fixup and result capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prem_d     = prem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        quot_res_d = quot_res_q;
        rem_res_d  = rem_res_q;

        a_neg_s    = signed_i & dividend_i[DATA_WIDTH-1];
        b_neg_s    = signed_i & divisor_i[DATA_WIDTH-1];

        // Shift {rem,quo} left; the sign of the old remainder picks sub or add.
        // The (DATA_WIDTH+1)-bit wrap is harmless: the true result always fits.
        dvsr_ext_s = {1'b0, dvsr_q};
        shifted_s  = {prem_q[DATA_WIDTH-1:0], quo_q[DATA_WIDTH-1]};
        if (prem_q[DATA_WIDTH]) begin
            step_s = shifted_s + dvsr_ext_s;
        end else begin
            step_s = shifted_s - dvsr_ext_s;
        end

        // Final remainder lies in [0, divisor) so DATA_WIDTH bits suffice.
        if (prem_q[DATA_WIDTH]) begin
            rem_fix_s = prem_q[DATA_WIDTH-1:0] + dvsr_q;
        end else begin
            rem_fix_s = prem_q[DATA_WIDTH-1:0];
        end

        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        quo_d   = magnitude(dividend_i, signed_i);
                        dvsr_d  = magnitude(divisor_i, signed_i);
                        prem_d  = {(DATA_WIDTH+1){1'b0}};
                        cnt_d   = CNT_INIT;
                        q_neg_d = a_neg_s ^ b_neg_s;
                        r_neg_d = a_neg_s;
                        if (divisor_i == ZERO_W) begin
                            quot_res_d = ALL_ONES;
                            rem_res_d  = dividend_i;
                            state_d    = ST_DONE;
                        end else if (signed_i && (dividend_i == MIN_INT) &&
                                     (divisor_i == ALL_ONES)) begin
                            quot_res_d = MIN_INT;
                            rem_res_d  = ZERO_W;
                            state_d    = ST_DONE;
                        end else begin
                            state_d = ST_ITER;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ITER: begin
                    prem_d = step_s;
                    quo_d  = {quo_q[DATA_WIDTH-2:0], ~step_s[DATA_WIDTH]};
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FIXUP;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
                ST_FIXUP: begin
                    quot_res_d = q_neg_q ? negate(quo_q) : quo_q;
                    rem_res_d  = r_neg_q ? negate(rem_fix_s) : rem_fix_s;
                    state_d    = ST_DONE;
                end
                ST_DONE: begin
                    if (result_ack_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    assign busy_o         = busy_q;
    assign result_valid_o = valid_q;
    assign quotient_o     = quot_res_q;
    assign remainder_o    = rem_res_q;

endmodule
